imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_starve_ctr.sv | 37 +++
 rtl/imem_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// ============================================================================
// imem_pkg: shared constants, requester index and address-check helper
// Rev 1.0
// ============================================================================
`default_nettype none

package imem_pkg;

  localparam int unsigned IMEM_WORD_W = 32;
  localparam int unsigned IMEM_DEPTH  = 32;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DEBUG = 1'b1
  } req_idx_e;

  // True for a misaligned address or a word index beyond the memory.
  function automatic logic addr_is_bad(input logic [IMEM_WORD_W-1:0] addr,
                                       input int unsigned            depth);
    logic [IMEM_WORD_W-1:0] w_idx;
    w_idx = {2'b00, addr[IMEM_WORD_W-1:2]};
    return (w_idx >= depth) || (addr[1:0] != 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_starve_ctr.sv
// ============================================================================
// imem_starve_ctr: saturating count of consecutive refused debug cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_starve_ctr
  import imem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_sat
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || !i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != C_MAX) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

  assign o_sat = (r_cnt == C_MAX);

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
// ============================================================================
// imem_arbiter: two-port (fetch/debug) arbiter for a combinational instruction
// memory. Optional macro: IMEM_ARB_ADDR_CHECK_EN enables address-error flags.
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH    = IMEM_DEPTH,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   f_req,
  input  logic [IMEM_WORD_W-1:0] f_addr,
  output logic                   f_gnt,
  output logic                   f_rvalid,
  output logic [IMEM_WORD_W-1:0] f_rdata,
  output logic                   f_rerr,
  input  logic                   d_req,
  input  logic [IMEM_WORD_W-1:0] d_addr,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [IMEM_WORD_W-1:0] d_rdata,
  output logic                   d_rerr,
  output logic [IMEM_WORD_W-1:0] mem_addr,
  input  logic [IMEM_WORD_W-1:0] mem_inst
);

`ifdef IMEM_ARB_ADDR_CHECK_EN
  localparam logic C_ADDR_CHECK = 1'b1;
`else
  localparam logic C_ADDR_CHECK = 1'b0;
`endif

  logic                   w_starved;
  logic                   w_f_gnt;
  logic                   w_d_gnt;
  req_idx_e               w_winner;
  logic                   w_err;
  logic [IMEM_WORD_W-1:0] w_load;

  logic                   r_f_rvalid;
  logic                   r_d_rvalid;
  logic [IMEM_WORD_W-1:0] r_f_rdata;
  logic [IMEM_WORD_W-1:0] r_d_rdata;

  imem_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk   (Clk),
    .rst   (Rst),
    .i_req (d_req),
    .i_gnt (w_d_gnt),
    .o_sat (w_starved)
  );

  // Fetch has priority unless debug has been refused MAX_WAIT cycles in a row.
  always_comb begin
    w_f_gnt  = 1'b0;
    w_d_gnt  = 1'b0;
    w_winner = REQ_FETCH;
    if (!Rst) begin
      if (d_req && (w_starved || !f_req)) begin
        w_d_gnt  = 1'b1;
        w_winner = REQ_DEBUG;
      end else if (f_req) begin
        w_f_gnt  = 1'b1;
      end
    end
  end

  assign mem_addr = (w_winner == REQ_DEBUG) ? d_addr : f_addr;
  assign w_err    = C_ADDR_CHECK && addr_is_bad(mem_addr, DEPTH);
  assign w_load   = w_err ? '0 : mem_inst;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_f_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_f_rvalid <= w_f_gnt;
      r_d_rvalid <= w_d_gnt;
      if (w_f_gnt) r_f_rdata <= w_load;
      if (w_d_gnt) r_d_rdata <= w_load;
    end
  end

`ifdef IMEM_ARB_ADDR_CHECK_EN
  logic r_f_rerr;
  logic r_d_rerr;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_f_rerr <= 1'b0;
      r_d_rerr <= 1'b0;
    end else begin
      r_f_rerr <= w_f_gnt && w_err;
      r_d_rerr <= w_d_gnt && w_err;
    end
  end

  assign f_rerr = r_f_rerr;
  assign d_rerr = r_d_rerr;
`else
  assign f_rerr = 1'b0;
  assign d_rerr = 1'b0;
`endif

  assign f_gnt    = w_f_gnt;
  assign d_gnt    = w_d_gnt;
  assign f_rvalid = r_f_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign f_rdata  = r_f_rdata;
  assign d_rdata  = r_d_rdata;

endmodule

`default_nettype wire
